// File: rtl/fetch_unit_if.sv
// Fetch unit port bundle: redirect input, instruction memory read port and
// decode-side valid/ready handshake.
interface fetch_unit_if #(
    parameter int width = 32
);
    logic             redirect_valid;
    logic [width-1:0] redirect_pc;
    logic [width-1:0] mem_read_address;
    logic             mem_read_enable;
    logic [width-1:0] mem_read_data;
    logic             instr_valid;
    logic [width-1:0] instr_data;
    logic [width-1:0] instr_pc;
    logic             instr_ready;

    // Fetch unit side.
    modport master (
        input  redirect_valid, redirect_pc, mem_read_data, instr_ready,
        output mem_read_address, mem_read_enable, instr_valid, instr_data, instr_pc
    );

    // Environment side: redirect source, memory and decode.
    modport slave (
        output redirect_valid, redirect_pc, mem_read_data, instr_ready,
        input  mem_read_address, mem_read_enable, instr_valid, instr_data, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a one-cycle memory,
// buffers returned words with their PC and hands them to decode. A redirect
// flushes everything in flight and restarts fetch at the new PC.
module fetch_unit #(
    parameter int               width    = 32,
    parameter int               depth    = 2,
    parameter logic [width-1:0] reset_pc = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);
    localparam int PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int CW = $clog2(depth + 1);
    localparam int OW = CW + 1;

    logic [width-1:0] fetch_pc_q, fetch_pc_d;
    logic             pending_q, pending_d;
    logic [width-1:0] pending_pc_q, pending_pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [width-1:0] buf_data_q [depth];
    logic [width-1:0] buf_pc_q   [depth];

    logic          redirect, head_valid, pop, push, credit, issue;
    logic [OW-1:0] occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake and issue decision; a redirect wins over credits and hides the head.
    always_comb begin
        redirect   = bus.redirect_valid;
        head_valid = (count_q != '0);
        pop        = head_valid && !redirect && bus.instr_ready;
        push       = pending_q && !redirect;
        occ        = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
        credit     = (occ < OW'(depth));
        issue      = redirect || credit || pop;
    end

    assign bus.mem_read_enable  = issue && !rst;
    assign bus.mem_read_address = redirect ? bus.redirect_pc : fetch_pc_q;
    assign bus.instr_valid      = head_valid && !redirect;
    assign bus.instr_data       = buf_data_q[rd_ptr_q];
    assign bus.instr_pc         = buf_pc_q[rd_ptr_q];

    // Next-state for PC, pending tag, occupancy and FIFO pointers.
    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_d    = 1'b0;
        pending_pc_d = pending_pc_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        if (redirect) begin
            fetch_pc_d   = bus.redirect_pc + width'(1);
            pending_d    = 1'b1;
            pending_pc_d = bus.redirect_pc;
            count_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
        end else begin
            if (issue) begin
                fetch_pc_d   = fetch_pc_q + width'(1);
                pending_d    = 1'b1;
                pending_pc_d = fetch_pc_q;
            end
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset drops anything in flight so stale responses never land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= reset_pc;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
        end
    end

    // Buffer storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= bus.mem_read_data;
            buf_pc_q[wr_ptr_q]   <= pending_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: registered memory model returning 0x1000+addr, a
// scoreboard of expected (pc, data) pairs popped on every accepted handshake,
// and per-scenario timing checks.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if #(.width(32)) fif ();

    fetch_unit #(.width(32), .depth(2), .reset_pc(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (fif.master)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Registered memory: word at addr is 0x1000+addr, one cycle after issue.
    always @(posedge clk)
        if (fif.mem_read_enable) fif.mem_read_data <= 32'h1000 + fif.mem_read_address;

    // Scoreboard: every accepted instruction must be the next expected one.
    always @(negedge clk) begin
        if (!rst && fif.instr_valid && fif.instr_ready) begin
            n_vec++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: got pc=%h data=%h, expected no delivery", fif.instr_pc, fif.instr_data);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (fif.instr_pc !== e.pc || fif.instr_data !== e.data) begin
                    n_err++;
                    $display("FAIL sb_order: got pc=%h data=%h, expected pc=%h data=%h",
                             fif.instr_pc, fif.instr_data, e.pc, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc   = start + 32'(i);
            e.data = 32'h1000 + e.pc;
            sbq.push_back(e);
        end
    endtask

    // Leaves the bench at the start of cycle 0 after reset release.
    task automatic do_reset();
        rst = 1'b1;
        sbq.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        n_vec++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d undelivered, expected 0", name, sbq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = '0;
        fif.instr_ready    = 1'b1;
        tick();
        tick();
        n_vec++;
        if (fif.mem_read_enable !== 1'b0) begin
            n_err++; $display("FAIL reset_en: got %b, expected 0", fif.mem_read_enable);
        end
        n_vec++;
        if (fif.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b, expected 0", fif.instr_valid);
        end
    endtask

    task automatic test_stream();
        fif.instr_ready = 1'b1;
        do_reset();
        exp_seq(32'h0, 8);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++;
            if (fif.instr_valid !== (c >= 2)) begin
                n_err++; $display("FAIL stream_valid c%0d: got %b, expected %b", c, fif.instr_valid, c >= 2);
            end
            tick();
        end
        fif.instr_ready = 1'b0;
        check_drained("stream");
    endtask

    task automatic test_backpressure();
        fif.instr_ready = 1'b0;
        do_reset();
        exp_seq(32'h0, 4);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                n_vec++;
                if (fif.mem_read_enable !== 1'b0 || fif.mem_read_address !== 32'h2) begin
                    n_err++;
                    $display("FAIL bp_hold c%0d: got en=%b addr=%h, expected en=0 addr=00000002",
                             c, fif.mem_read_enable, fif.mem_read_address);
                end
                n_vec++;
                if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 32'h0) begin
                    n_err++;
                    $display("FAIL bp_head c%0d: got valid=%b pc=%h, expected valid=1 pc=00000000",
                             c, fif.instr_valid, fif.instr_pc);
                end
            end
            tick();
            if (c == 6)  fif.instr_ready = 1'b1;
            if (c == 10) fif.instr_ready = 1'b0;
        end
        check_drained("bp");
    endtask

    task automatic test_redirect_mid();
        fif.instr_ready = 1'b1;
        do_reset();
        exp_seq(32'h0, 5);
        exp_seq(32'h40, 3);
        for (int c = 0; c < 12; c++) begin
            if (c == 7) begin
                fif.redirect_valid = 1'b1;
                fif.redirect_pc    = 32'h40;
                #1;
                n_vec++;
                if (fif.instr_valid !== 1'b0 || fif.mem_read_enable !== 1'b1 || fif.mem_read_address !== 32'h40) begin
                    n_err++;
                    $display("FAIL redir_cycle: got valid=%b en=%b addr=%h, expected valid=0 en=1 addr=00000040",
                             fif.instr_valid, fif.mem_read_enable, fif.mem_read_address);
                end
            end
            if (c == 8) fif.redirect_valid = 1'b0;
            @(negedge clk);
            if (c == 8) begin
                n_vec++;
                if (fif.instr_valid !== 1'b0) begin
                    n_err++; $display("FAIL redir_gap: got valid=%b, expected 0", fif.instr_valid);
                end
            end
            if (c == 9) begin
                n_vec++;
                if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 32'h40 || fif.instr_data !== 32'h1040) begin
                    n_err++;
                    $display("FAIL redir_first: got valid=%b pc=%h data=%h, expected valid=1 pc=00000040 data=00001040",
                             fif.instr_valid, fif.instr_pc, fif.instr_data);
                end
            end
            tick();
        end
        fif.instr_ready = 1'b0;
        check_drained("redir");
    endtask

    task automatic test_redirect_full();
        fif.instr_ready = 1'b0;
        do_reset();
        exp_seq(32'h40, 2);
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                fif.redirect_valid = 1'b1;
                fif.redirect_pc    = 32'h40;
                #1;
                n_vec++;
                if (fif.mem_read_enable !== 1'b1 || fif.mem_read_address !== 32'h40 || fif.instr_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL full_redir: got en=%b addr=%h valid=%b, expected en=1 addr=00000040 valid=0",
                             fif.mem_read_enable, fif.mem_read_address, fif.instr_valid);
                end
            end
            if (c == 5) begin
                fif.redirect_valid = 1'b0;
                fif.instr_ready    = 1'b1;
            end
            @(negedge clk);
            if (c == 3) begin
                n_vec++;
                if (fif.mem_read_enable !== 1'b0) begin
                    n_err++; $display("FAIL full_stall: got en=%b, expected 0", fif.mem_read_enable);
                end
            end
            if (c == 5) begin
                n_vec++;
                if (fif.instr_valid !== 1'b0) begin
                    n_err++; $display("FAIL full_flush: got valid=%b, expected 0", fif.instr_valid);
                end
            end
            if (c == 6) begin
                n_vec++;
                if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 32'h40) begin
                    n_err++;
                    $display("FAIL full_first: got valid=%b pc=%h, expected valid=1 pc=00000040",
                             fif.instr_valid, fif.instr_pc);
                end
            end
            tick();
        end
        fif.instr_ready = 1'b0;
        check_drained("full");
    endtask

    task automatic test_back_to_back();
        fif.instr_ready = 1'b1;
        do_reset();
        exp_seq(32'h0, 3);
        exp_seq(32'h20, 3);
        for (int c = 0; c < 11; c++) begin
            if (c == 5) begin
                fif.redirect_valid = 1'b1;
                fif.redirect_pc    = 32'h10;
            end
            if (c == 6) begin
                fif.redirect_pc = 32'h20;
                #1;
                n_vec++;
                if (fif.mem_read_enable !== 1'b1 || fif.mem_read_address !== 32'h20) begin
                    n_err++;
                    $display("FAIL b2b_issue: got en=%b addr=%h, expected en=1 addr=00000020",
                             fif.mem_read_enable, fif.mem_read_address);
                end
            end
            if (c == 7) fif.redirect_valid = 1'b0;
            @(negedge clk);
            if (c == 8) begin
                n_vec++;
                if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 32'h20) begin
                    n_err++;
                    $display("FAIL b2b_first: got valid=%b pc=%h, expected valid=1 pc=00000020",
                             fif.instr_valid, fif.instr_pc);
                end
            end
            tick();
        end
        fif.instr_ready = 1'b0;
        check_drained("b2b");
    endtask

    task automatic test_async_reset();
        fif.instr_ready = 1'b1;
        do_reset();
        exp_seq(32'h0, 4);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 5) tick();
        end
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (fif.instr_valid !== 1'b0 || fif.mem_read_enable !== 1'b0) begin
            n_err++;
            $display("FAIL arst_drop: got valid=%b en=%b, expected valid=0 en=0",
                     fif.instr_valid, fif.mem_read_enable);
        end
        check_drained("arst_pre");
        tick();
        tick();
        rst = 1'b0;
        exp_seq(32'h0, 3);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            if (fif.instr_valid !== (c >= 2)) begin
                n_err++; $display("FAIL arst_restart c%0d: got valid=%b, expected %b", c, fif.instr_valid, c >= 2);
            end
            tick();
        end
        fif.instr_ready = 1'b0;
        check_drained("arst");
    endtask

    task automatic test_wrap();
        fif.instr_ready = 1'b1;
        do_reset();
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'hFFFF_FFFF;
        #1;
        n_vec++;
        if (fif.mem_read_enable !== 1'b1 || fif.mem_read_address !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL wrap_issue: got en=%b addr=%h, expected en=1 addr=ffffffff",
                     fif.mem_read_enable, fif.mem_read_address);
        end
        exp_seq(32'hFFFF_FFFF, 3);
        tick();
        fif.redirect_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                n_vec++;
                if (fif.instr_valid !== 1'b1 || fif.instr_pc !== 32'h0) begin
                    n_err++;
                    $display("FAIL wrap_zero: got valid=%b pc=%h, expected valid=1 pc=00000000",
                             fif.instr_valid, fif.instr_pc);
                end
            end
            tick();
        end
        fif.instr_ready = 1'b0;
        check_drained("wrap");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_mid();
        test_redirect_full();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, expected completion");
        $fatal(1);
    end
endmodule
